// File: rtl/branch_pkg.sv
// Shared types and constants for the branch update unit and its BTB training queue.
package branch_pkg;

  localparam int BTB_ADDR_WIDTH         = 26;
  localparam int BRANCH_FALLTHROUGH_INC = 4;

  typedef struct packed {
    logic [BTB_ADDR_WIDTH-1:0] pc;
    logic [BTB_ADDR_WIDTH-1:0] target;
  } btb_update_t;

endpackage

// File: rtl/branch_update_unit_if.sv
// Bundle of the execute-side resolution, fetch redirect, BTB write and statistics signals.
interface branch_update_unit_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int CNT_WIDTH  = 32
);
  logic                  i_res_valid;
  logic [ADDR_WIDTH-1:0] i_res_pc;
  logic                  i_res_taken;
  logic [ADDR_WIDTH-1:0] i_res_target;
  logic                  i_pred_hit;
  logic [ADDR_WIDTH-1:0] i_pred_target;
  logic                  o_res_ready;
  logic                  o_redirect;
  logic [ADDR_WIDTH-1:0] o_redirect_pc;
  logic                  i_btb_busy;
  logic                  o_btb_we;
  logic [ADDR_WIDTH-1:0] o_btb_pc;
  logic [ADDR_WIDTH-1:0] o_btb_target;
  logic [CNT_WIDTH-1:0]  o_branch_count;
  logic [CNT_WIDTH-1:0]  o_mispredict_count;

  modport slave (
    input  i_res_valid, i_res_pc, i_res_taken, i_res_target, i_pred_hit, i_pred_target, i_btb_busy,
    output o_res_ready, o_redirect, o_redirect_pc, o_btb_we, o_btb_pc, o_btb_target,
           o_branch_count, o_mispredict_count
  );

  modport master (
    output i_res_valid, i_res_pc, i_res_taken, i_res_target, i_pred_hit, i_pred_target, i_btb_busy,
    input  o_res_ready, o_redirect, o_redirect_pc, o_btb_we, o_btb_pc, o_btb_target,
           o_branch_count, o_mispredict_count
  );
endinterface

// File: rtl/btb_update_fifo.sv
// Small power-of-two FIFO holding pending BTB training writes; head is read straight from storage.
module btb_update_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 52
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Push is refused while full even if the head pops in the same cycle.
  always_comb begin
    full      = (count_r == (PW+1)'(DEPTH));
    empty     = (count_r == {(PW+1){1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    head      = mem_r[rd_ptr_r];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end
endmodule

// File: rtl/branch_update_unit.sv
// Checks resolved branches against their fetch-time BTB prediction, redirects fetch on
// mispredict, keeps statistics and queues BTB training writes.
module branch_update_unit
  import branch_pkg::*;
#(
  parameter int ADDR_WIDTH = 26,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 32
) (
  input logic                clk,
  input logic                rst,
  branch_update_unit_if.slave bus
);
  logic [ADDR_WIDTH-1:0]   fall_through_s;
  logic [ADDR_WIDTH-1:0]   pred_next_s;
  logic [ADDR_WIDTH-1:0]   actual_next_s;
  logic                    accept_s;
  logic                    mispredict_s;
  logic                    push_s;
  logic                    full_s;
  logic                    empty_s;
  logic                    btb_we_s;
  logic [2*ADDR_WIDTH-1:0] head_s;
  logic                    redirect_r;
  logic [ADDR_WIDTH-1:0]   redirect_pc_r;
  logic [CNT_WIDTH-1:0]    branch_cnt_r;
  logic [CNT_WIDTH-1:0]    mispredict_cnt_r;

  // Resolutions arriving during a redirect are wrong-path and are ignored entirely.
  always_comb begin
    fall_through_s = bus.i_res_pc + ADDR_WIDTH'(BRANCH_FALLTHROUGH_INC);
    pred_next_s    = bus.i_pred_hit  ? bus.i_pred_target : fall_through_s;
    actual_next_s  = bus.i_res_taken ? bus.i_res_target  : fall_through_s;
    accept_s       = bus.i_res_valid & ~full_s & ~redirect_r & ~rst;
    mispredict_s   = accept_s & (pred_next_s != actual_next_s);
    push_s         = accept_s & bus.i_res_taken &
                     (~bus.i_pred_hit | (bus.i_pred_target != bus.i_res_target));
    btb_we_s       = ~empty_s & ~bus.i_btb_busy & ~rst;
  end

  btb_update_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2*ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (btb_we_s),
    .din   ({bus.i_res_pc, bus.i_res_target}),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // Redirect pulse, redirect target and saturating statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_r       <= 1'b0;
      redirect_pc_r    <= {ADDR_WIDTH{1'b0}};
      branch_cnt_r     <= {CNT_WIDTH{1'b0}};
      mispredict_cnt_r <= {CNT_WIDTH{1'b0}};
    end else begin
      redirect_r <= mispredict_s;
      if (mispredict_s) redirect_pc_r <= actual_next_s;
      if (accept_s && (branch_cnt_r != {CNT_WIDTH{1'b1}}))
        branch_cnt_r <= branch_cnt_r + CNT_WIDTH'(1);
      if (mispredict_s && (mispredict_cnt_r != {CNT_WIDTH{1'b1}}))
        mispredict_cnt_r <= mispredict_cnt_r + CNT_WIDTH'(1);
    end
  end

  assign bus.o_res_ready        = ~full_s & ~rst;
  assign bus.o_redirect         = redirect_r;
  assign bus.o_redirect_pc      = redirect_pc_r;
  assign bus.o_btb_we           = btb_we_s;
  assign bus.o_btb_pc           = head_s[2*ADDR_WIDTH-1:ADDR_WIDTH];
  assign bus.o_btb_target       = head_s[ADDR_WIDTH-1:0];
  assign bus.o_branch_count     = branch_cnt_r;
  assign bus.o_mispredict_count = mispredict_cnt_r;
endmodule

// File: tb/tb_branch_update_unit.sv
// Directed bench for branch_update_unit: a queue-based reference model checked every cycle,
// plus hand-computed literal checkpoints. Counters are 4 bits wide so saturation is reachable.
module tb_branch_update_unit;
  import branch_pkg::*;

  localparam int AW    = 26;
  localparam int CW    = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  branch_update_unit_if #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  branch_update_unit #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: queue of pending writes, redirect state and saturating counts.
  btb_update_t     mq[$];
  logic            m_redir;
  logic [AW-1:0]   m_rpc;
  logic [CW-1:0]   m_bc;
  logic [CW-1:0]   m_mc;
  bit              m_init = 1'b0;

  always @(posedge clk) begin : model
    logic          acc;
    logic [AW-1:0] pn;
    logic [AW-1:0] an;
    btb_update_t   e;
    if (rst) begin
      mq.delete();
      m_redir = 1'b0;
      m_rpc   = '0;
      m_bc    = '0;
      m_mc    = '0;
      m_init  = 1'b1;
    end else begin
      acc = bus.i_res_valid && (mq.size() < DEPTH) && !m_redir;
      pn  = bus.i_pred_hit  ? bus.i_pred_target : bus.i_res_pc + 26'd4;
      an  = bus.i_res_taken ? bus.i_res_target  : bus.i_res_pc + 26'd4;
      if (mq.size() > 0 && !bus.i_btb_busy) void'(mq.pop_front());
      if (acc && bus.i_res_taken && !(bus.i_pred_hit && bus.i_pred_target == bus.i_res_target)) begin
        e.pc     = bus.i_res_pc;
        e.target = bus.i_res_target;
        mq.push_back(e);
      end
      m_redir = acc && (pn != an);
      if (m_redir) m_rpc = an;
      if (acc && m_bc != 4'hF) m_bc = m_bc + 4'd1;
      if (acc && (pn != an) && m_mc != 4'hF) m_mc = m_mc + 4'd1;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin : compare
    logic exp_ready;
    logic exp_we;
    if (m_init) begin
      exp_ready = !rst && (mq.size() < DEPTH);
      exp_we    = !rst && (mq.size() > 0) && !bus.i_btb_busy;
      chk("m_ready",     bus.o_res_ready,        exp_ready);
      chk("m_btb_we",    bus.o_btb_we,           exp_we);
      if (exp_we) begin
        chk("m_btb_pc",     bus.o_btb_pc,     mq[0].pc);
        chk("m_btb_target", bus.o_btb_target, mq[0].target);
      end
      chk("m_redirect",    bus.o_redirect,         m_redir);
      chk("m_redirect_pc", bus.o_redirect_pc,      m_rpc);
      chk("m_branch_cnt",  bus.o_branch_count,     m_bc);
      chk("m_mispred_cnt", bus.o_mispredict_count, m_mc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] pc, input logic tk,
                       input logic [AW-1:0] tg, input logic h, input logic [AW-1:0] pt);
    bus.i_res_valid   = v;
    bus.i_res_pc      = pc;
    bus.i_res_taken   = tk;
    bus.i_res_target  = tg;
    bus.i_pred_hit    = h;
    bus.i_pred_target = pt;
  endtask

  task automatic idle();
    drive(1'b0, 26'h0, 1'b0, 26'h0, 1'b0, 26'h0);
  endtask

  initial begin
    idle();
    bus.i_btb_busy = 1'b0;

    // Reset held for several cycles; outputs must all be low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_redirect", bus.o_redirect,         64'd0);
    chk("rst_we",       bus.o_btb_we,           64'd0);
    chk("rst_ready",    bus.o_res_ready,        64'd0);
    chk("rst_bcount",   bus.o_branch_count,     64'd0);
    chk("rst_mcount",   bus.o_mispredict_count, 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", bus.o_res_ready, 64'd1);

    // Taken BTB miss.
    drive(1'b1, 26'h100, 1'b1, 26'h200, 1'b0, 26'h0);
    tick();
    idle();
    @(negedge clk);
    chk("miss_redirect",   bus.o_redirect,         64'd1);
    chk("miss_rpc",        bus.o_redirect_pc,      64'h200);
    chk("miss_we",         bus.o_btb_we,           64'd1);
    chk("miss_btb_pc",     bus.o_btb_pc,           64'h100);
    chk("miss_btb_target", bus.o_btb_target,       64'h200);
    chk("miss_bcount",     bus.o_branch_count,     64'd1);
    chk("miss_mcount",     bus.o_mispredict_count, 64'd1);

    // Correct taken hit.
    tick();
    drive(1'b1, 26'h104, 1'b1, 26'h300, 1'b1, 26'h300);
    tick();
    idle();
    @(negedge clk);
    chk("hit_redirect", bus.o_redirect,         64'd0);
    chk("hit_we",       bus.o_btb_we,           64'd0);
    chk("hit_bcount",   bus.o_branch_count,     64'd2);
    chk("hit_mcount",   bus.o_mispredict_count, 64'd1);

    // False taken with fall-through wrap, then a wrong-path resolution during the redirect.
    tick();
    drive(1'b1, 26'h3FFFFFC, 1'b0, 26'h0, 1'b1, 26'h400);
    tick();
    drive(1'b1, 26'h500, 1'b1, 26'h600, 1'b0, 26'h0);
    @(negedge clk);
    chk("wrap_redirect", bus.o_redirect,         64'd1);
    chk("wrap_rpc",      bus.o_redirect_pc,      64'h0);
    chk("wrap_we",       bus.o_btb_we,           64'd0);
    chk("wrap_bcount",   bus.o_branch_count,     64'd3);
    chk("wrap_mcount",   bus.o_mispredict_count, 64'd2);
    tick();
    idle();
    @(negedge clk);
    chk("drop_redirect", bus.o_redirect,         64'd0);
    chk("drop_rpc",      bus.o_redirect_pc,      64'h0);
    chk("drop_we",       bus.o_btb_we,           64'd0);
    chk("drop_bcount",   bus.o_branch_count,     64'd3);
    chk("drop_mcount",   bus.o_mispredict_count, 64'd2);

    // Backpressure: fill the queue while the BTB is busy.
    tick();
    bus.i_btb_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'((i + 1) * 16), 1'b1, AW'((i + 1) * 16 + 4096), 1'b0, 26'h0);
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    chk("bp_ready",  bus.o_res_ready,        64'd0);
    chk("bp_we",     bus.o_btb_we,           64'd0);
    chk("bp_bcount", bus.o_branch_count,     64'd7);
    chk("bp_mcount", bus.o_mispredict_count, 64'd6);
    tick();
    bus.i_btb_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_we",     bus.o_btb_we,     64'd1);
      chk("drain_pc",     bus.o_btb_pc,     64'((i + 1) * 16));
      chk("drain_target", bus.o_btb_target, 64'((i + 1) * 16 + 4096));
      chk("drain_ready",  bus.o_res_ready,  (i > 0) ? 64'd1 : 64'd0);
      tick();
    end
    @(negedge clk);
    chk("drained_we", bus.o_btb_we, 64'd0);

    // Saturation: ten not-taken mispredicts push both 4-bit counters past all-ones.
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, AW'(2048 + k * 8), 1'b0, 26'h0, 1'b1, 26'h400);
      tick();
      idle();
      tick();
    end
    @(negedge clk);
    chk("sat_bcount", bus.o_branch_count,     64'hF);
    chk("sat_mcount", bus.o_mispredict_count, 64'hF);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_update_unit.md
Name: branch_update_unit

Overview:
- Sits between the execute stage and the branch target buffer.
- Consumes resolved branches from execute and compares each outcome against the fetch-time BTB prediction that travelled down the pipe.
- Issues a registered redirect on mispredict; counts branches and mispredicts.
- Queues BTB training writes in a small FIFO and drains them into the BTB write port (we/pc/target) one per cycle.

Parameters:
- ADDR_WIDTH, 26, width of PCs and targets (byte addresses).
- FIFO_DEPTH, 4, update-queue entries; power of two, at least 2.
- CNT_WIDTH, 32, width of the statistics counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- i_res_valid  in  1  resolved branch present from execute.
- i_res_pc  in  ADDR_WIDTH  PC of the resolved branch.
- i_res_taken  in  1  actual direction.
- i_res_target  in  ADDR_WIDTH  actual taken target.
- i_pred_hit  in  1  BTB hit recorded at fetch (hit means predicted taken).
- i_pred_target  in  ADDR_WIDTH  BTB target used at fetch.
- o_res_ready  out  1  unit can accept a resolution.
- o_redirect  out  1  one-cycle fetch redirect pulse.
- o_redirect_pc  out  ADDR_WIDTH  correct next PC.
- i_btb_busy  in  1  BTB cannot take a write this cycle.
- o_btb_we  out  1  BTB write enable.
- o_btb_pc  out  ADDR_WIDTH  PC (tag/index source) to write.
- o_btb_target  out  ADDR_WIDTH  target to write.
- o_branch_count  out  CNT_WIDTH  accepted branches.
- o_mispredict_count  out  CNT_WIDTH  mispredicts.

Behaviour:
- Reset:
  - FIFO empty, pointers 0.
  - o_redirect=0, o_redirect_pc=0, counters=0.
  - o_btb_we=0; o_res_ready=1 the cycle after rst deasserts.
  - Reset mid-operation discards all queued updates and any pending redirect.
- Accept: i_res_valid & o_res_ready & ~o_redirect.
  - o_res_ready = ~full.
  - A resolution presented while o_redirect=1 is wrong-path: dropped, with no redirect, no enqueue and no counter change.
- Prediction and outcome, all addition modulo 2^ADDR_WIDTH:
  - fall-through = i_res_pc + 4.
  - Predicted next = i_pred_hit ? i_pred_target : fall-through.
  - Actual next = i_res_taken ? i_res_target : fall-through.
  - Mispredict = accept & (predicted next != actual next).
- Redirect:
  - Registered; asserts exactly one cycle after a mispredicting accept.
  - o_redirect_pc holds the actual next PC and keeps its value when o_redirect=0.
- Enqueue on accept & i_res_taken & (~i_pred_hit | i_pred_target != i_res_target).
  - Entry = {i_res_pc, i_res_target}.
  - Not-taken branches never enqueue; the BTB has no invalidate.
- Drain (combinational from the registered FIFO head):
  - o_btb_we = ~empty & ~i_btb_busy; o_btb_pc/o_btb_target = head entry.
  - Head pops when o_btb_we=1.
  - No bypass: earliest write is the cycle after the accept.
- Simultaneous push and pop:
  - Allowed when not full; count unchanged.
  - When full, push is blocked even if a pop occurs that cycle.
- Pointers wrap at FIFO_DEPTH; entries drain strictly in FIFO order.
- Counters:
  - o_branch_count +1 per accept; o_mispredict_count +1 per mispredict.
  - Both saturate at all-ones and are registered.

Decomposition:
- Package branch_pkg holds:
  - typedef btb_update_t {pc, target}, each ADDR_WIDTH bits.
  - constant BRANCH_FALLTHROUGH_INC = 4.
- One sub-module: btb_update_fifo.
  - Parameterised depth; push, pop, full, empty, head.
  - Synchronous active-high rst.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> all outputs 0 during reset; o_res_ready=1 afterwards; counters 0.
- Taken BTB miss: pc=0x100, target=0x200, pred_hit=0 -> next cycle o_redirect=1 with redirect_pc 0x200; o_btb_we=1 with pc 0x100, target 0x200; counts 1/1.
- Correct hit: pc=0x104, taken, target 0x300, pred_hit=1, pred_target 0x300 -> no redirect, no write; branch_count +1, mispredict_count unchanged.
- False taken with address wrap: pc=0x3FFFFFC, pred_hit=1, pred_target 0x400, not taken -> redirect to 0x0000000; no enqueue. A second mispredicting resolution presented in the redirect cycle is dropped and counters do not change.
- Backpressure: i_btb_busy=1, four taken misses (pcs 0x10, 0x20, 0x30, 0x40) -> o_res_ready=0 after the 4th. Release busy -> four writes on consecutive cycles in order 0x10..0x40; ready returns to 1 the cycle after the first pop.
- Counter saturation: preload via forced counters at all-ones minus 1, then two mispredicts -> both counters hold at all-ones.
